// File: rtl/knn_result_streamer.sv
// Captures the KNN core's classification array on the rising edge of done and
// streams it out one result per valid/ready beat. Optional histogram: RESULT_HISTOGRAM_EN.
module knn_result_streamer #(
  parameter int unsigned  QUERY_DATA_POINTS = 8,
  parameter int unsigned  CLASSIFICATIONS   = 4,
  localparam int unsigned CW = $clog2(CLASSIFICATIONS),
  localparam int unsigned IW = $clog2(QUERY_DATA_POINTS),
  localparam int unsigned HW = $clog2(QUERY_DATA_POINTS + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               knn_done,
  input  logic [QUERY_DATA_POINTS-1:0][CW-1:0] classif,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [IW-1:0]                      out_index,
  output logic [CW-1:0]                      out_class,
  output logic                               out_last,
  output logic                               busy,
  output logic                               overrun
`ifdef RESULT_HISTOGRAM_EN
  ,
  output logic [CLASSIFICATIONS-1:0][HW-1:0] class_count,
  output logic                               hist_valid
`endif
);

  localparam logic [IW-1:0] LAST_IDX = IW'(QUERY_DATA_POINTS - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_e;

  state_e                              state_q, state_d;
  logic [QUERY_DATA_POINTS-1:0][CW-1:0] buf_q, buf_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic [CW-1:0]                       class_q, class_d;
  logic                                valid_q, valid_d;
  logic                                last_q, last_d;
  logic                                busy_q, busy_d;
  logic                                overrun_q, overrun_d;
  logic                                done_q;
  logic                                rise;
  logic                                accept;
  logic                                capture;

  assign rise   = knn_done & ~done_q;
  assign accept = valid_q & out_ready;

  // Next state; a rise coinciding with the final handshake starts a new capture.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: capture = rise;
      S_STREAM: begin
        if (accept && last_q) begin
          capture = rise;
          if (!rise) state_d = S_IDLE;
        end else begin
          if (accept) idx_d = idx_q + IW'(1);
          if (rise)   overrun_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      buf_d   = classif;
      idx_d   = '0;
      state_d = S_STREAM;
    end
    valid_d = (state_d == S_STREAM);
    busy_d  = valid_d;
    last_d  = valid_d && (idx_d == LAST_IDX);
    class_d = buf_d[idx_d];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      idx_q     <= '0;
      class_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      class_q   <= class_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      done_q    <= knn_done;
    end
  end

  assign out_valid = valid_q;
  assign out_index = idx_q;
  assign out_class = class_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

`ifdef RESULT_HISTOGRAM_EN
  logic [CLASSIFICATIONS-1:0][HW-1:0] cnt_q, cnt_d;
  logic                               hv_q, hv_d;

  // Counts accepted beats per class; a capture restarts the histogram.
  always_comb begin
    cnt_d = cnt_q;
    hv_d  = hv_q;
    if (capture) begin
      cnt_d = '0;
      hv_d  = 1'b0;
    end else if (accept) begin
      if (32'(class_q) < CLASSIFICATIONS) cnt_d[class_q] = cnt_q[class_q] + HW'(1);
      if (last_q) hv_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      hv_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hv_q  <= hv_d;
    end
  end

  assign class_count = cnt_q;
  assign hist_valid  = hv_q;
`endif

endmodule

// File: tb/tb_knn_result_streamer.sv
// Bench for knn_result_streamer: constant vector table, directed corner sequences
// and a random run against a queue-based model of the result stream.
module tb_knn_result_streamer;

  localparam int unsigned QDP = 8;
  localparam int unsigned NC  = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned IW  = 3;
  localparam int unsigned HW  = 4;
  localparam int unsigned CLW = QDP * CW;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    knn_done;
  logic [QDP-1:0][CW-1:0]  classif;
  logic                    out_valid;
  logic                    out_ready;
  logic [IW-1:0]           out_index;
  logic [CW-1:0]           out_class;
  logic                    out_last;
  logic                    busy;
  logic                    overrun;
`ifdef RESULT_HISTOGRAM_EN
  logic [NC-1:0][HW-1:0]   class_count;
  logic                    hist_valid;
`endif

  knn_result_streamer #(.QUERY_DATA_POINTS(QDP), .CLASSIFICATIONS(NC)) dut (
    .clk        (clk),
    .reset      (reset),
    .knn_done   (knn_done),
    .classif    (classif),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_class  (out_class),
    .out_last   (out_last),
    .busy       (busy),
    .overrun    (overrun)
`ifdef RESULT_HISTOGRAM_EN
    ,
    .class_count(class_count),
    .hist_valid (hist_valid)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: the queue holds the beats still owed to the consumer.
  typedef struct { int idx; int cls; } beat_t;
  beat_t m_q[$];
  logic  m_prev_done;
  logic  m_ovr;
  int    m_cnt[NC];
  logic  m_hv;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_capture(input logic [QDP-1:0][CW-1:0] c);
    beat_t b;
    for (int i = 0; i < int'(QDP); i++) begin
      b.idx = i;
      b.cls = int'(c[i]);
      m_q.push_back(b);
    end
    for (int k = 0; k < int'(NC); k++) m_cnt[k] = 0;
    m_hv = 1'b0;
  endtask

  task automatic model_check();
    chk("valid", int'(out_valid), int'(m_q.size() > 0));
    chk("busy", int'(busy), int'(m_q.size() > 0));
    chk("overrun", int'(overrun), int'(m_ovr));
    if (m_q.size() > 0) begin
      chk("index", int'(out_index), m_q[0].idx);
      chk("class", int'(out_class), m_q[0].cls);
      chk("last", int'(out_last), int'(m_q[0].idx == int'(QDP) - 1));
    end
`ifdef RESULT_HISTOGRAM_EN
    chk("hist_valid", int'(hist_valid), int'(m_hv));
    for (int k = 0; k < int'(NC); k++) chk("class_count", int'(class_count[k]), m_cnt[k]);
`endif
  endtask

  // One clock: drive inputs after a falling edge, advance the model, check at the next falling edge.
  task automatic step(input logic d, input logic r, input logic [QDP-1:0][CW-1:0] c);
    beat_t b;
    logic  rise;
    knn_done  = d;
    out_ready = r;
    classif   = c;
    rise = d && !m_prev_done;
    if (m_q.size() > 0 && r) begin
      b = m_q.pop_front();
      if (b.cls < int'(NC)) m_cnt[b.cls]++;
      if (b.idx == int'(QDP) - 1) m_hv = 1'b1;
    end
    if (rise) begin
      if (m_q.size() == 0) model_capture(c);
      else m_ovr = 1'b1;
    end
    m_prev_done = d;
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  // Asserts reset away from a clock edge, checks the asynchronous clear, releases two cycles later.
  task automatic apply_reset();
    reset = 1'b0;
    m_q.delete();
    m_prev_done = 1'b0;
    m_ovr = 1'b0;
    m_hv = 1'b0;
    for (int k = 0; k < int'(NC); k++) m_cnt[k] = 0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_index", int'(out_index), 0);
    chk("rst_class", int'(out_class), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic done;
    logic ready;
    logic exp_valid;
    int   exp_index;
    int   exp_class;
    logic exp_last;
  } vec_t;

  vec_t                   tbl[10];
  int                     basic_vals[QDP] = '{3, 1, 0, 2, 2, 1, 3, 0};
  logic [QDP-1:0][CW-1:0] basic_data;
  logic [QDP-1:0][CW-1:0] alt_data;
  logic                   rd;
  logic                   dn;

  initial begin
    reset = 1'b0;
    knn_done = 1'b0;
    out_ready = 1'b0;
    classif = '0;
    for (int i = 0; i < int'(QDP); i++) begin
      basic_data[i] = CW'(basic_vals[i]);
      alt_data[i]   = CW'(i % int'(NC));
    end
    // Row 0 raises done; rows 1..7 accept one beat each; row 8 takes the last beat.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 0, 3, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1, 1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 2, 0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 3, 2, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 4, 2, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 5, 1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 6, 3, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 7, 0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b0};

    // Basic stream from the vector table.
    apply_reset();
    step(1'b0, 1'b1, basic_data);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].done, tbl[i].ready, basic_data);
      chk("tbl_valid", int'(out_valid), int'(tbl[i].exp_valid));
      chk("tbl_busy", int'(busy), int'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk("tbl_index", int'(out_index), tbl[i].exp_index);
        chk("tbl_class", int'(out_class), tbl[i].exp_class);
        chk("tbl_last", int'(out_last), int'(tbl[i].exp_last));
      end
`ifdef RESULT_HISTOGRAM_EN
      if (i >= 8) begin
        chk("tbl_hist_valid", int'(hist_valid), 1);
        for (int k = 0; k < int'(NC); k++) chk("tbl_class_count", int'(class_count[k]), 2);
      end
`endif
    end
    step(1'b0, 1'b1, basic_data);
    step(1'b1, 1'b0, alt_data);
    chk("recapture_valid", int'(out_valid), 1);
`ifdef RESULT_HISTOGRAM_EN
    chk("recapture_hist_valid", int'(hist_valid), 0);
    for (int k = 0; k < int'(NC); k++) chk("recapture_count", int'(class_count[k]), 0);
`endif

    // Backpressure with classif scrambled after capture.
    apply_reset();
    step(1'b1, 1'b0, basic_data);
    for (int i = 0; i < 40; i++) begin
      rd = ((i % 4) == 0) || ((i % 4) == 3);
      step(1'b1, rd, CLW'($urandom));
    end
    chk("bp_done_idle", int'(out_valid), 0);

    // Overrun: done re-rises at beat 3 while busy.
    apply_reset();
    step(1'b1, 1'b1, basic_data);
    step(1'b1, 1'b1, basic_data);
    step(1'b1, 1'b1, basic_data);
    step(1'b0, 1'b1, basic_data);
    step(1'b1, 1'b1, alt_data);
    chk("ovr_set", int'(overrun), 1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, alt_data);
    chk("ovr_idle", int'(out_valid), 0);
    step(1'b0, 1'b1, alt_data);
    step(1'b1, 1'b1, alt_data);
    chk("ovr_run2_class0", int'(out_class), 0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, alt_data);
    chk("ovr_sticky", int'(overrun), 1);

    // Back-to-back: the rise lands on the last-beat handshake.
    apply_reset();
    step(1'b1, 1'b1, basic_data);
    for (int i = 1; i < 7; i++) step(1'b1, 1'b1, basic_data);
    step(1'b0, 1'b1, basic_data);
    chk("b2b_pre_last", int'(out_last), 1);
    step(1'b1, 1'b1, alt_data);
    chk("b2b_valid", int'(out_valid), 1);
    chk("b2b_index", int'(out_index), 0);
    chk("b2b_class", int'(out_class), int'(alt_data[0]));
    chk("b2b_overrun", int'(overrun), 0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, alt_data);

    // Reset mid-stream at beat 4 with done held high.
    apply_reset();
    step(1'b1, 1'b1, basic_data);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, basic_data);
    chk("mid_index4", int'(out_index), 4);
    apply_reset();
    step(1'b1, 1'b1, alt_data);
    chk("mid_recapture_valid", int'(out_valid), 1);
    chk("mid_recapture_index", int'(out_index), 0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, alt_data);

    // Random traffic against the model.
    apply_reset();
    dn = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) dn = ~dn;
      rd = ($urandom_range(0, 3) != 0);
      step(dn, rd, CLW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/knn_result_streamer.md
Name: knn_result_streamer

Overview:
- Sits directly downstream of the KNN core and consumes its `classif` array and `done` flag.
- On the rising edge of `done`, it snapshots all QUERY_DATA_POINTS classifications into a local buffer.
- It then streams them out one per beat over a valid/ready interface, in order: index, class, last-flag.
- Optionally accumulates a per-class histogram of the streamed results.

Parameters:
- QUERY_DATA_POINTS, 8, number of query results captured per KNN run.
- CLASSIFICATIONS, 4, number of distinct classes; CW = $clog2(CLASSIFICATIONS), IW = $clog2(QUERY_DATA_POINTS), HW = $clog2(QUERY_DATA_POINTS+1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- knn_done  in  1  KNN core done flag; a level, held high after completion.
- classif  in  [QUERY_DATA_POINTS][CW]  KNN result array; sampled only at capture.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accepts beat.
- out_index  out  IW  query point index of the current beat.
- out_class  out  CW  classification of the current beat.
- out_last  out  1  high on the beat with out_index == QUERY_DATA_POINTS-1.
- busy  out  1  high while in STREAM.
- overrun  out  1  sticky; a done rise was dropped while busy.
- class_count  out  [CLASSIFICATIONS][HW]  histogram (RESULT_HISTOGRAM_EN only).
- hist_valid  out  1  histogram complete (RESULT_HISTOGRAM_EN only).

Behaviour:
- Reset (reset==0, async): state=IDLE; out_valid, out_last, busy, overrun, hist_valid = 0; out_index=0; out_class=0; done_q=0; buffer=0; class_count all 0.
- Edge detect: done_q registers knn_done each cycle; rise = knn_done & ~done_q. A held-high done produces exactly one rise.
- FSM states: IDLE, STREAM.
- IDLE: on rise, load buffer[i]=classif[i] for all i, set idx=0, go to STREAM. out_valid is high the cycle after the edge at which rise was sampled (1-cycle capture latency).
- STREAM, outputs: out_valid=1, out_index=idx, out_class=buffer[idx], out_last=(idx==QUERY_DATA_POINTS-1). All outputs are registered or decoded from registers.
- STREAM, stall: out_valid high with out_ready low holds every output stable. No beat is skipped or duplicated.
- STREAM, handshake: a beat transfers when out_valid & out_ready.
  - Non-last beat: idx increments by 1.
  - Last beat: return to IDLE; out_valid falls the next cycle.
- Rise during STREAM, not on the last handshake: dropped, buffer untouched, overrun set to 1. overrun stays set until reset.
- Rise on the same cycle as the last-beat handshake: treated as a new capture. Go directly to STREAM with a fresh buffer and idx=0, no overrun, out_valid stays high continuously.
- classif changing outside the capture cycle has no effect.
- Class values >= CLASSIFICATIONS (non-power-of-2 case) are streamed unchanged.
- busy = (state==STREAM).
- Reset asserted mid-stream: immediate return to reset values. A knn_done still high after reset release produces a rise, because done_q resets to 0.

Optional Feature:
- Macro: RESULT_HISTOGRAM_EN.
- Defined:
  - class_count and hist_valid ports exist.
  - On capture: all counts clear to 0 and hist_valid clears.
  - On each accepted beat: class_count[out_class] increments by 1. Out-of-range classes are not counted.
  - On last-beat acceptance: hist_valid goes to 1 the next cycle and holds until the next capture or reset.
  - Counts never exceed QUERY_DATA_POINTS.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic stream: reset low 2 cycles then high; classif={3,1,0,2,2,1,3,0}; knn_done rises; out_ready=1.
  - Expected: out_valid high 1 cycle later.
  - Expected: 8 consecutive beats with index 0..7, classes 3,1,0,2,2,1,3,0, out_last only on index 7; busy falls after.
- Backpressure: same data, out_ready toggled 1,0,0,1,...
  - Expected: outputs are stable on every stalled cycle and the class sequence is unchanged.
  - Expected: change classif after capture; the streamed values still match the captured ones.
- Overrun: knn_done pulses low then high again at beat 3 (out_ready=1).
  - Expected: the stream finishes with the original data and overrun=1 sticks.
  - Expected: a second run streams the new data; overrun stays 1 until reset.
- Back-to-back capture: a done rise aligned with the last-beat handshake.
  - Expected: out_valid never drops; the next beat is index 0 of the new data; overrun=0.
- Reset mid-stream: assert reset at beat 4 with knn_done held high.
  - Expected: all outputs 0 immediately.
  - Expected: after release, a fresh capture and index 0 on the following cycle.
- RESULT_HISTOGRAM_EN with the basic-stream data.
  - Expected: class_count = {2,2,2,2} and hist_valid=1 the cycle after the last beat.
  - Expected: the next capture clears hist_valid and all counts.
